// File: rtl/global_buffer_pkg.sv
// Shared GLB types and bank geometry constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package global_buffer_pkg;

   // Bank geometry defaults
   localparam int GLB_BANK_ADDR_WIDTH  = 17;
   localparam int GLB_BANK_DATA_WIDTH  = 64;
   localparam int GLB_BANK_BYTE_OFFSET = 3;

   // Bank stream reader job state
   typedef enum logic [1:0] {
      RD_IDLE,
      RD_ISSUE,
      RD_DRAIN,
      RD_DONE
   } rd_state_e;

endpackage

// File: rtl/glb_sync_fifo.sv
// Small synchronous FIFO with register-array storage.
// Latency: a word pushed in cycle t is visible on pop_data in cycle t+1.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
//
// Ports: clk, reset (async, active-high); push/push_data write side; pop/pop_data read side
// (pop_data shows the head entry); full, empty, count status.
module glb_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   // When full, the entry being popped frees the slot the push writes into.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/glb_bank_stream_reader.sv
// Packet-read initiator for one GLB bank: turns a (start, stride, count) job into bank reads
// and streams the returned words out. Latency: request t -> bank return t+3 -> strm_valid t+4.
// Backpressure: strm_ready stalls the return FIFO; credits stop issue before the FIFO could overflow.
//
// Ports: clk, reset (async, active-high); cfg_start/cfg_start_addr/cfg_stride/cfg_num_words job setup;
// busy, done (1-cycle), err (sticky); bank_cfg_busy blocks issue; packet_rd_en/packet_rd_addr requests;
// packet_rd_data/packet_rd_data_valid returns; strm_data/strm_valid/strm_ready/strm_last output stream;
// perf_stall_cnt stall counter, present only when GLB_RD_PERF_CNT_EN is defined (otherwise tied to 0).
module glb_bank_stream_reader
   import global_buffer_pkg::*;
#(
   parameter int BANK_ADDR_WIDTH  = GLB_BANK_ADDR_WIDTH,
   parameter int BANK_DATA_WIDTH  = GLB_BANK_DATA_WIDTH,
   parameter int BANK_BYTE_OFFSET = GLB_BANK_BYTE_OFFSET,
   parameter int RD_LATENCY       = 3,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cfg_start,
   input  logic [BANK_ADDR_WIDTH-1:0]  cfg_start_addr,
   input  logic [7:0]                  cfg_stride,
   input  logic [15:0]                 cfg_num_words,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   input  logic                        bank_cfg_busy,
   output logic                        packet_rd_en,
   output logic [BANK_ADDR_WIDTH-1:0]  packet_rd_addr,
   input  logic [BANK_DATA_WIDTH-1:0]  packet_rd_data,
   input  logic                        packet_rd_data_valid,
   output logic [BANK_DATA_WIDTH-1:0]  strm_data,
   output logic                        strm_valid,
   input  logic                        strm_ready,
   output logic                        strm_last,
   output logic [31:0]                 perf_stall_cnt
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // RD_LATENCY only documents the bank; the credit scheme works for any latency.
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RD_LATENCY < 1) begin : g_param_check
      $error("glb_bank_stream_reader: FIFO_DEPTH must be a power of two >= 2, RD_LATENCY >= 1");
   end

   rd_state_e                   state_q, state_d;
   logic [BANK_ADDR_WIDTH-1:0]  addr_q;
   logic [BANK_ADDR_WIDTH-1:0]  stride_bytes;
   logic [7:0]                  stride_q;
   logic [15:0]                 issue_rem_q;
   logic [15:0]                 ret_rem_q;
   logic [CW-1:0]               outstanding_q;
   logic [CW-1:0]               fifo_count;
   logic [CW:0]                 credit_used;
   logic                        credit_ok;
   logic                        start_accept;
   logic                        issue;
   logic                        pop;
   logic                        ret_ok;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [BANK_DATA_WIDTH:0]    fifo_dout;
   logic                        head_last;
   logic                        err_q;

   assign start_accept = (state_q == RD_IDLE) && cfg_start;
   assign stride_bytes = BANK_ADDR_WIDTH'(stride_q) << BANK_BYTE_OFFSET;

   // Every word either in flight or sitting in the FIFO holds a credit. The word leaving the
   // FIFO this cycle releases its slot long before a request issued now can return, which is
   // what lets the reader sustain one word per cycle with a FIFO only RD_LATENCY+1 deep.
   assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
   assign credit_ok   = credit_used < ((CW+1)'(FIFO_DEPTH) + (CW+1)'(pop));

   // Returns are only legal against an outstanding request and with room in the FIFO.
   assign ret_ok = packet_rd_data_valid && (outstanding_q != '0) && (!fifo_full || pop);

   assign strm_valid = !fifo_empty;
   assign pop        = strm_valid && strm_ready;
   assign head_last  = fifo_dout[BANK_DATA_WIDTH];
   assign strm_data  = fifo_dout[BANK_DATA_WIDTH-1:0];
   assign strm_last  = strm_valid && head_last;

   assign packet_rd_en   = issue;
   assign packet_rd_addr = addr_q;
   assign err            = err_q;

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (cfg_start) begin
               state_d = (cfg_num_words == 16'd0) ? RD_DONE : RD_ISSUE;
            end
         end
         RD_ISSUE: begin
            busy  = 1'b1;
            issue = (issue_rem_q != 16'd0) && !bank_cfg_busy && credit_ok;
            if (issue && issue_rem_q == 16'd1) begin
               state_d = RD_DRAIN;
            end
         end
         RD_DRAIN: begin
            busy = 1'b1;
            if (pop && head_last) begin
               state_d = RD_DONE;
            end
         end
         RD_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = RD_IDLE;
         end
         default: state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= RD_IDLE;
         addr_q        <= '0;
         stride_q      <= '0;
         issue_rem_q   <= '0;
         ret_rem_q     <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_q + CW'(issue) - CW'(ret_ok);
         if (start_accept) begin
            addr_q      <= {cfg_start_addr[BANK_ADDR_WIDTH-1:BANK_BYTE_OFFSET], {BANK_BYTE_OFFSET{1'b0}}};
            stride_q    <= cfg_stride;
            issue_rem_q <= cfg_num_words;
            ret_rem_q   <= cfg_num_words;
            err_q       <= packet_rd_data_valid && !ret_ok;
         end else begin
            if (issue) begin
               addr_q      <= addr_q + stride_bytes;
               issue_rem_q <= issue_rem_q - 16'd1;
            end
            if (ret_ok) begin
               ret_rem_q <= ret_rem_q - 16'd1;
            end
            if (packet_rd_data_valid && !ret_ok) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   // Returns arrive in request order, so the last accepted return is the job's final word.
   glb_sync_fifo #(
      .WIDTH (BANK_DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_ret_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (ret_ok),
      .push_data ({(ret_rem_q == 16'd1), packet_rd_data}),
      .pop       (pop),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

`ifdef GLB_RD_PERF_CNT_EN
   logic        stall;
   logic [31:0] perf_q;

   assign stall = (state_q == RD_ISSUE) && (issue_rem_q != 16'd0) && !issue;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_q <= '0;
      end else if (start_accept) begin
         perf_q <= '0;
      end else if (stall && perf_q != 32'hFFFF_FFFF) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_stall_cnt = perf_q;
`else
   assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_glb_bank_stream_reader.sv
// Bench for glb_bank_stream_reader: directed jobs plus randomized jobs checked against an
// address/data reference model; bank returns mem[addr] 3 cycles after each request.
// Expected perf_stall_cnt depends on GLB_RD_PERF_CNT_EN.
module tb_glb_bank_stream_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_start;
   logic [16:0] cfg_start_addr;
   logic [7:0]  cfg_stride;
   logic [15:0] cfg_num_words;
   logic        busy, done, err;
   logic        bank_cfg_busy;
   logic        packet_rd_en;
   logic [16:0] packet_rd_addr;
   logic [63:0] packet_rd_data;
   logic        packet_rd_data_valid;
   logic [63:0] strm_data;
   logic        strm_valid;
   logic        strm_ready;
   logic        strm_last;
   logic [31:0] perf_stall_cnt;

   int tests = 0;
   int failed = 0;
   int cyc = 0;
   logic [31:0] salt;

   // Monitor records
   logic [16:0] req_addr_q[$];
   int          req_cyc_q[$];
   logic [63:0] st_data_q[$];
   bit          st_last_q[$];
   int          st_cyc_q[$];
   int          done_cyc_q[$];
   int          first_valid_cyc = -1;
   int          busy_viol = 0;
   int          start_cyc = 0;

   // Bank model
   logic [2:0]  bv;
   logic [16:0] ba0, ba1, ba2;
   logic        spur;
   logic [63:0] spur_data;

   glb_bank_stream_reader dut (
      .clk                  (clk),
      .reset                (reset),
      .cfg_start            (cfg_start),
      .cfg_start_addr       (cfg_start_addr),
      .cfg_stride           (cfg_stride),
      .cfg_num_words        (cfg_num_words),
      .busy                 (busy),
      .done                 (done),
      .err                  (err),
      .bank_cfg_busy        (bank_cfg_busy),
      .packet_rd_en         (packet_rd_en),
      .packet_rd_addr       (packet_rd_addr),
      .packet_rd_data       (packet_rd_data),
      .packet_rd_data_valid (packet_rd_data_valid),
      .strm_data            (strm_data),
      .strm_valid           (strm_valid),
      .strm_ready           (strm_ready),
      .strm_last            (strm_last),
      .perf_stall_cnt       (perf_stall_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] mem_word(input logic [16:0] a);
      return {salt, 15'd0, a};
   endfunction

   // Word i of a job: aligned start plus i*stride words, modulo the bank size.
   function automatic logic [16:0] exp_addr(input logic [16:0] a, input logic [7:0] s, input int i);
      logic [31:0] t;
      t = 32'(a & 17'h1FFF8) + 32'(i) * 32'(s) * 32'd8;
      return t[16:0];
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         bv <= 3'b000;
      end else begin
         bv  <= {bv[1:0], packet_rd_en};
         ba0 <= packet_rd_addr;
         ba1 <= ba0;
         ba2 <= ba1;
      end
   end

   assign packet_rd_data_valid = bv[2] | spur;
   assign packet_rd_data       = spur ? spur_data : mem_word(ba2);

   always @(negedge clk) begin
      if (!reset) begin
         if (packet_rd_en) begin
            req_addr_q.push_back(packet_rd_addr);
            req_cyc_q.push_back(cyc);
            if (bank_cfg_busy) busy_viol <= busy_viol + 1;
         end
         if (strm_valid && first_valid_cyc < 0) first_valid_cyc <= cyc;
         if (strm_valid && strm_ready) begin
            st_data_q.push_back(strm_data);
            st_last_q.push_back(strm_last);
            st_cyc_q.push_back(cyc);
         end
         if (done) done_cyc_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
      end
   endtask

   task automatic clear_mon();
      req_addr_q.delete();
      req_cyc_q.delete();
      st_data_q.delete();
      st_last_q.delete();
      st_cyc_q.delete();
      done_cyc_q.delete();
      first_valid_cyc = -1;
      busy_viol = 0;
   endtask

   task automatic start_job(input logic [16:0] a, input logic [7:0] s, input logic [15:0] n);
      @(posedge clk); #1;
      clear_mon();
      cfg_start_addr = a;
      cfg_stride     = s;
      cfg_num_words  = n;
      cfg_start      = 1'b1;
      start_cyc      = cyc;
      @(posedge clk); #1;
      cfg_start      = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rnd);
      int n = 0;
      while (done_cyc_q.size() == 0 && n < budget) begin
         @(posedge clk); #1;
         if (rnd) begin
            strm_ready    = ($urandom_range(0, 3) != 0);
            bank_cfg_busy = ($urandom_range(0, 4) == 0);
         end
         n++;
      end
      check("done_seen", 0, 64'(done_cyc_q.size() != 0), 64'd1);
      @(posedge clk); #1;
      strm_ready    = 1'b1;
      bank_cfg_busy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_job(input logic [16:0] a, input logic [7:0] s, input int n);
      check("req_count", 0, 64'(req_addr_q.size()), 64'(n));
      for (int i = 0; i < n && i < req_addr_q.size(); i++)
         check("req_addr", i, 64'(req_addr_q[i]), 64'(exp_addr(a, s, i)));
      check("word_count", 0, 64'(st_data_q.size()), 64'(n));
      for (int i = 0; i < n && i < st_data_q.size(); i++) begin
         check("strm_data", i, st_data_q[i], mem_word(exp_addr(a, s, i)));
         check("strm_last", i, 64'(st_last_q[i]), 64'(i == n - 1));
      end
      check("done_count", 0, 64'(done_cyc_q.size()), 64'd1);
      if (done_cyc_q.size() == 1 && st_cyc_q.size() == n && n > 0)
         check("done_after_last", 0, 64'(done_cyc_q[0] - st_cyc_q[n-1]), 64'd1);
      check("req_while_cfg_busy", 0, 64'(busy_viol), 64'd0);
      check("err_after_job", 0, 64'(err), 64'd0);
   endtask

   initial begin
      logic [16:0] a;
      logic [7:0]  s;
      logic [15:0] n;
      logic [31:0] exp_perf;
      int          k;

      salt           = $urandom;
      reset          = 1'b1;
      cfg_start      = 1'b0;
      cfg_start_addr = '0;
      cfg_stride     = '0;
      cfg_num_words  = '0;
      bank_cfg_busy  = 1'b0;
      strm_ready     = 1'b0;
      spur           = 1'b0;
      spur_data      = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", 0, 64'(busy), 64'd0);
      check("rst_done", 0, 64'(done), 64'd0);
      check("rst_err", 0, 64'(err), 64'd0);
      check("rst_rd_en", 0, 64'(packet_rd_en), 64'd0);
      check("rst_rd_addr", 0, 64'(packet_rd_addr), 64'd0);
      check("rst_strm_valid", 0, 64'(strm_valid), 64'd0);
      check("rst_strm_data", 0, strm_data, 64'd0);
      check("rst_strm_last", 0, 64'(strm_last), 64'd0);
      check("rst_perf", 0, 64'(perf_stall_cnt), 64'd0);
      @(posedge clk); #1;
      reset      = 1'b0;
      strm_ready = 1'b1;

      // Basic job, full throughput
      start_job(17'h00100, 8'd1, 16'd8);
      wait_done(100, 1'b0);
      check_job(17'h00100, 8'd1, 8);
      for (int i = 0; i < 8 && i < req_cyc_q.size(); i++)
         check("req_consecutive", i, 64'(req_cyc_q[i] - req_cyc_q[0]), 64'(i));
      if (req_cyc_q.size() > 0)
         check("first_valid_lat", 0, 64'(first_valid_cyc - req_cyc_q[0]), 64'd4);
      check("perf_no_stall", 0, 64'(perf_stall_cnt), 64'd0);

      // Stream stalled: credits stop issue at FIFO depth
      strm_ready = 1'b0;
      a = 17'($urandom) & 17'h1FFF8;
      start_job(a, 8'd1, 16'd8);
      repeat (20) @(negedge clk);
      check("stall_req_count", 0, 64'(req_addr_q.size()), 64'd4);
      check("stall_valid", 0, 64'(strm_valid), 64'd1);
      check("stall_head", 0, strm_data, mem_word(exp_addr(a, 8'd1, 0)));
      repeat (2) @(negedge clk);
      check("stall_head_held", 0, strm_data, mem_word(exp_addr(a, 8'd1, 0)));
      check("stall_err", 0, 64'(err), 64'd0);
      @(posedge clk); #1;
      strm_ready = 1'b1;
      wait_done(100, 1'b0);
      check_job(a, 8'd1, 8);

      // Bank busy with SRAM config for 5 cycles mid-job
      a = 17'($urandom);
      start_job(a, 8'd3, 16'd8);
      k = 0;
      while (req_addr_q.size() < 2 && k < 20) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk); #1;
      bank_cfg_busy = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      bank_cfg_busy = 1'b0;
      wait_done(100, 1'b0);
      check_job(a, 8'd3, 8);
`ifdef GLB_RD_PERF_CNT_EN
      exp_perf = 32'd5;
`else
      exp_perf = 32'd0;
`endif
      check("perf_cfg_busy", 0, 64'(perf_stall_cnt), 64'(exp_perf));

      // Address wrap at top of bank
      start_job(17'h1FFF8, 8'd2, 16'd3);
      wait_done(100, 1'b0);
      check_job(17'h1FFF8, 8'd2, 3);
      if (req_addr_q.size() == 3) begin
         check("wrap_addr", 0, 64'(req_addr_q[0]), 64'h1FFF8);
         check("wrap_addr", 1, 64'(req_addr_q[1]), 64'h00008);
         check("wrap_addr", 2, 64'(req_addr_q[2]), 64'h00018);
      end

      // Zero-length job
      start_job(17'h00040, 8'd1, 16'd0);
      repeat (4) @(negedge clk);
      check("num0_req_count", 0, 64'(req_addr_q.size()), 64'd0);
      check("num0_done_count", 0, 64'(done_cyc_q.size()), 64'd1);
      if (done_cyc_q.size() == 1)
         check("num0_done_lat_le2", 0, 64'(done_cyc_q[0] - start_cyc <= 2 && done_cyc_q[0] > start_cyc), 64'd1);
      check("num0_idle", 0, 64'(busy), 64'd0);

      // Second start while busy is ignored
      start_job(17'h02000, 8'd1, 16'd6);
      @(posedge clk); #1;
      cfg_start_addr = 17'h0;
      cfg_num_words  = 16'd0;
      cfg_start      = 1'b1;
      @(posedge clk); #1;
      cfg_start      = 1'b0;
      wait_done(100, 1'b0);
      check_job(17'h02000, 8'd1, 6);

      // Spurious return while idle
      @(posedge clk); #1;
      spur_data = 64'($urandom);
      spur      = 1'b1;
      @(posedge clk); #1;
      spur      = 1'b0;
      @(negedge clk);
      check("spur_err", 0, 64'(err), 64'd1);
      check("spur_no_data", 0, 64'(strm_valid), 64'd0);
      repeat (3) @(negedge clk);
      check("spur_err_sticky", 0, 64'(err), 64'd1);
      check("spur_still_empty", 0, 64'(strm_valid), 64'd0);
      start_job(17'h00808, 8'd5, 16'd2);
      @(negedge clk);
      check("err_cleared_by_start", 0, 64'(err), 64'd0);
      wait_done(100, 1'b0);
      check_job(17'h00808, 8'd5, 2);

      // Randomized jobs with random backpressure and config traffic
      for (int j = 0; j < 8; j++) begin
         a = 17'($urandom);
         s = 8'($urandom);
         n = 16'($urandom_range(1, 12));
         start_job(a, s, n);
         wait_done(600, 1'b1);
         check_job(a, s, int'(n));
      end

      // Reset mid-job aborts everything
      strm_ready = 1'b0;
      start_job(17'h00200, 8'd1, 16'd8);
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      clear_mon();
      @(negedge clk);
      check("midrst_busy", 0, 64'(busy), 64'd0);
      check("midrst_valid", 0, 64'(strm_valid), 64'd0);
      check("midrst_rd_en", 0, 64'(packet_rd_en), 64'd0);
      check("midrst_perf", 0, 64'(perf_stall_cnt), 64'd0);
      @(posedge clk); #1;
      reset      = 1'b0;
      strm_ready = 1'b1;
      repeat (8) @(negedge clk);
      check("midrst_no_words", 0, 64'(st_data_q.size()), 64'd0);
      check("midrst_no_done", 0, 64'(done_cyc_q.size()), 64'd0);
      check("midrst_no_req", 0, 64'(req_addr_q.size()), 64'd0);
      check("midrst_err", 0, 64'(err), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
